// File: rtl/matrix_multiplier.sv
// Multiplies the 4x4 channel matrix H by one of 16 scaled permutation/phase codewords C_q.
// Results stream out row-major, one saturated complex element per Hq_out_valid pulse.
module matrix_multiplier #(
    parameter int Q         = 8,
    parameter int N         = 16,
    parameter int ACC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          q_index,
    input  logic                H_in_valid,
    output logic [1:0]          i_counter,
    output logic [1:0]          k_counter,
    input  logic signed [N-1:0] H_in_r,
    input  logic signed [N-1:0] H_in_i,
    output logic                hq_one_matrix_done,
    output logic                all_16_hq_done,
    output logic                Hq_out_valid,
    output logic signed [N-1:0] Hq_out_r,
    output logic signed [N-1:0] Hq_out_i
);
    localparam int CW = Q + 2;
    localparam logic signed [CW-1:0] ONE      = {2'b01, {Q{1'b0}}};
    localparam logic signed [CW-1:0] NEG_ONE  = -ONE;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-N+1){1'b1}}, {(N-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t state_reg, state_next;
    logic   accept, mac_en, last_mac;

    logic [3:0] q_reg;
    logic [1:0] i_reg, c_reg, k_reg;
    logic signed [ACC_WIDTH-1:0] acc_r_reg, acc_i_reg, res_r_reg, res_i_reg;
    logic emit_reg, last_reg;

    logic [1:0] col_sel;
    logic signed [CW-1:0] cr, ci;
    logic signed [ACC_WIDTH-1:0] hr_x, hi_x, cr_x, ci_x, term_r, term_i;

    function automatic logic signed [N-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [ACC_WIDTH-1:0] s;
        s = v >>> Q;
        if (s > SAT_MAX)
            return SAT_MAX[N-1:0];
        else if (s < SAT_MIN)
            return SAT_MIN[N-1:0];
        else
            return s[N-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_mac) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept   = (state_reg == IDLE) && start;
        mac_en   = (state_reg == CALC) && H_in_valid;
        last_mac = mac_en && (k_reg == 2'd3) && (c_reg == 2'd3) && (i_reg == 2'd3);
    end

    // C_q[k][c] is non-zero only where k selects the shifted column; w sets the phase.
    always_comb begin
        col_sel = c_reg + q_reg[1:0];
        cr = '0;
        ci = '0;
        if (k_reg == col_sel) begin
            case (q_reg[3:2])
                2'd0: cr = ONE;
                2'd1: ci = ONE;
                2'd2: cr = NEG_ONE;
                default: ci = NEG_ONE;
            endcase
        end
        hr_x   = {{(ACC_WIDTH-N){H_in_r[N-1]}}, H_in_r};
        hi_x   = {{(ACC_WIDTH-N){H_in_i[N-1]}}, H_in_i};
        cr_x   = {{(ACC_WIDTH-CW){cr[CW-1]}}, cr};
        ci_x   = {{(ACC_WIDTH-CW){ci[CW-1]}}, ci};
        term_r = hr_x * cr_x - hi_x * ci_x;
        term_i = hr_x * ci_x + hi_x * cr_x;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg              <= '0;
            i_reg              <= '0;
            c_reg              <= '0;
            k_reg              <= '0;
            acc_r_reg          <= '0;
            acc_i_reg          <= '0;
            res_r_reg          <= '0;
            res_i_reg          <= '0;
            emit_reg           <= 1'b0;
            last_reg           <= 1'b0;
            Hq_out_valid       <= 1'b0;
            Hq_out_r           <= '0;
            Hq_out_i           <= '0;
            hq_one_matrix_done <= 1'b0;
            all_16_hq_done     <= 1'b0;
        end else begin
            // Output stage runs one cycle behind the final accumulate of each element.
            emit_reg           <= 1'b0;
            Hq_out_valid       <= emit_reg;
            hq_one_matrix_done <= emit_reg && last_reg;
            all_16_hq_done     <= emit_reg && last_reg && (q_reg == 4'd15);
            if (emit_reg) begin
                Hq_out_r <= saturate(res_r_reg);
                Hq_out_i <= saturate(res_i_reg);
            end

            if (accept) begin
                q_reg     <= q_index;
                i_reg     <= '0;
                c_reg     <= '0;
                k_reg     <= '0;
                acc_r_reg <= '0;
                acc_i_reg <= '0;
            end else if (mac_en) begin
                if (k_reg == 2'd3) begin
                    res_r_reg <= acc_r_reg + term_r;
                    res_i_reg <= acc_i_reg + term_i;
                    acc_r_reg <= '0;
                    acc_i_reg <= '0;
                    emit_reg  <= 1'b1;
                    last_reg  <= (i_reg == 2'd3) && (c_reg == 2'd3);
                    k_reg     <= '0;
                    c_reg     <= c_reg + 2'd1;
                    if (c_reg == 2'd3)
                        i_reg <= i_reg + 2'd1;
                end else begin
                    acc_r_reg <= acc_r_reg + term_r;
                    acc_i_reg <= acc_i_reg + term_i;
                    k_reg     <= k_reg + 2'd1;
                end
            end
        end
    end

    assign i_counter = i_reg;
    assign k_counter = k_reg;
endmodule

// File: tb/tb_matrix_multiplier.sv
// Randomized scoreboard bench for matrix_multiplier: a driver pushes expected elements,
// a negedge monitor pops and compares them whenever Hq_out_valid is seen.
module tb_matrix_multiplier;
    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        q_index = '0;
    logic              H_in_valid = 1'b0;
    logic [1:0]        i_counter, k_counter;
    logic signed [15:0] H_in_r, H_in_i;
    logic              hq_one_matrix_done, all_16_hq_done, Hq_out_valid;
    logic signed [15:0] Hq_out_r, Hq_out_i;

    logic signed [15:0] hr [4][4];
    logic signed [15:0] hi [4][4];

    typedef struct {
        int r;
        int i;
        bit done;
        bit all;
        int cyc;
    } exp_t;
    exp_t sb[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    matrix_multiplier #(.Q(8), .N(16), .ACC_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .q_index(q_index), .H_in_valid(H_in_valid),
        .i_counter(i_counter), .k_counter(k_counter), .H_in_r(H_in_r), .H_in_i(H_in_i),
        .hq_one_matrix_done(hq_one_matrix_done), .all_16_hq_done(all_16_hq_done),
        .Hq_out_valid(Hq_out_valid), .Hq_out_r(Hq_out_r), .Hq_out_i(Hq_out_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign H_in_r = hr[i_counter][k_counter];
    assign H_in_i = hi[i_counter][k_counter];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: Hq[i][c] = w * H[i][(c+s) mod 4], w = j^(q>>2), saturated to 16 bits.
    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic model(input int q, input int i, input int c, output int er, output int ei);
        int r, m, col;
        col = (c + (q % 4)) % 4;
        r = int'(hr[i][col]);
        m = int'(hi[i][col]);
        case (q / 4)
            0: begin er = r;  ei = m;  end
            1: begin er = -m; ei = r;  end
            2: begin er = -r; ei = -m; end
            default: begin er = m; ei = -r; end
        endcase
        er = sat16(er);
        ei = sat16(ei);
    endtask

    task automatic push_expected(input int q, input int n_max, input int base, input bit timed,
                                 input int stall_from, input int stall_len);
        exp_t e;
        for (int n = 0; n < n_max; n++) begin
            model(q, n / 4, n % 4, e.r, e.i);
            e.done = (n == 15);
            e.all  = (n == 15) && (q == 15);
            e.cyc  = timed ? base + 4 * n + 5 + ((n >= stall_from) ? stall_len : 0) : -1;
            sb.push_back(e);
        end
    endtask

    // Monitor: compares each presented element, and flags stray pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (Hq_out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hq_r", int'(Hq_out_r), e.r);
                    chk("hq_i", int'(Hq_out_i), e.i);
                    chk("matrix_done", int'(hq_one_matrix_done), int'(e.done));
                    chk("all16_done", int'(all_16_hq_done), int'(e.all));
                    if (e.cyc >= 0) chk("latency_cycle", cyc, e.cyc);
                    $display("out r=%0d i=%0d done=%0d all=%0d cycle=%0d",
                             Hq_out_r, Hq_out_i, hq_one_matrix_done, all_16_hq_done, cyc);
                end
            end else if (hq_one_matrix_done || all_16_hq_done) begin
                chk("stray_done_pulse", 1, 0);
            end
        end
    end

    task automatic load_ramp();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                hr[i][k] = 16'(4 * i + k + 1);
                hi[i][k] = 16'(-(4 * i + k + 1));
            end
    endtask

    task automatic load_random();
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                hr[i][k] = 16'($urandom_range(0, 65535));
                hi[i][k] = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'($urandom_range(0, 65535));
            end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_i_counter"}, int'(i_counter), 0);
        chk({tag, "_k_counter"}, int'(k_counter), 0);
    endtask

    task automatic run_matrix(input int q, input bit rand_valid);
        int se;
        @(negedge clk);
        se = cyc + 1;
        push_expected(q, 16, se, !rand_valid, 99, 0);
        $display("start q=%0d rand_valid=%0d edge=%0d", q, rand_valid, se);
        start = 1'b1;
        q_index = 4'(q);
        H_in_valid = 1'b1;
        for (int t = 0; t < 400 && sb.size() > 0; t++) begin
            @(negedge clk);
            start = 1'b0;
            H_in_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        H_in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("post_run");
    endtask

    task automatic robustness();
        int se;
        load_ramp();
        @(negedge clk);
        se = cyc + 1;
        // Elements 0..5 finish before the reset; element 1 onward is delayed by the stall.
        push_expected(0, 6, se, 1'b1, 1, 3);
        $display("start q=0 robustness edge=%0d", se);
        start = 1'b1;
        q_index = 4'd0;
        H_in_valid = 1'b1;
        while (cyc + 1 <= se + 30) begin
            @(negedge clk);
            start = (cyc + 1 == se + 10);
            q_index = (cyc + 1 == se + 10) ? 4'd5 : 4'd0;
            H_in_valid = !((cyc + 1 >= se + 7) && (cyc + 1 <= se + 9));
            rst = (cyc + 1 == se + 30);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        H_in_valid = 1'b1;
        $display("reset mid-calc at cycle %0d", cyc);
        chk("rst_valid", int'(Hq_out_valid), 0);
        chk("rst_done", int'(hq_one_matrix_done), 0);
        chk("rst_all16", int'(all_16_hq_done), 0);
        chk("rst_hq_r", int'(Hq_out_r), 0);
        chk("rst_hq_i", int'(Hq_out_i), 0);
        check_idle("rst");
        chk("rst_pending_expected", sb.size(), 0);
        sb.delete();
        repeat (8) @(negedge clk);
        run_matrix(0, 1'b0);
    endtask

    initial begin
        load_ramp();
        repeat (3) @(negedge clk);
        chk("reset_valid", int'(Hq_out_valid), 0);
        chk("reset_hq_r", int'(Hq_out_r), 0);
        chk("reset_hq_i", int'(Hq_out_i), 0);
        chk("reset_done", int'(hq_one_matrix_done), 0);
        check_idle("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_matrix(0, 1'b0);
        run_matrix(1, 1'b0);
        run_matrix(4, 1'b0);
        run_matrix(15, 1'b0);
        hr[0][0] = 16'sh8000;
        hi[0][0] = 16'sh0000;
        run_matrix(8, 1'b0);

        robustness();

        for (int r = 0; r < 6; r++) begin
            load_random();
            run_matrix(int'($urandom_range(0, 15)), (r % 2) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
